// File: rtl/forwarding_exec_pipe.sv
// Execute / data-memory / writeback back end of the 5-stage MIPS pipeline.
// Holds the register file and data memory; operand forwarding is steered externally.
module forwarding_exec_pipe #(
  parameter int DM_AW = 6,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      RA,
  input  logic [4:0]      RB,
  input  logic [15:0]     imm,
  input  logic [5:0]      op_dec,
  input  logic            imm_sel,
  input  logic [1:0]      mux_sel_A,
  input  logic [1:0]      mux_sel_B,
  input  logic            mem_en_ex,
  input  logic            mem_rw_ex,
  input  logic [4:0]      RW_dm,
  input  logic            mem_mux_sel_dm,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_addr,
  output logic            wb_en
);

  localparam int DM_DEPTH = 1 << DM_AW;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_ALU  = 2'b01,
    FWD_WB   = 2'b10,
    FWD_ZERO = 2'b11
  } fwd_sel_e;

  logic [XLEN-1:0] rf   [32];
  logic [XLEN-1:0] dmem [DM_DEPTH];

  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] store_q;
  logic            mem_en_q;
  logic            mem_rw_q;
  logic [XLEN-1:0] wb_q;
  logic [4:0]      wb_addr_q;
  logic            wb_en_q;

  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] alu_res;
  alu_op_e         alu_op;
  fwd_sel_e        sel_a;
  fwd_sel_e        sel_b;

  logic [DM_AW-1:0] dm_addr;
  logic [XLEN-1:0]  dm_rdata;
  logic [XLEN-1:0]  wb_next;
  logic             unused_op_bits;

  // Register 0 is forced to zero on read so it never depends on reset having run.
  assign rf_a = (RA == 5'd0) ? '0 : rf[RA];
  assign rf_b = (RB == 5'd0) ? '0 : rf[RB];

  assign sel_a   = fwd_sel_e'(mux_sel_A);
  assign sel_b   = fwd_sel_e'(mux_sel_B);
  assign imm_ext = {{(XLEN-16){imm[15]}}, imm};
  assign alu_op  = alu_op_e'(op_dec[2:0]);
  assign unused_op_bits = ^op_dec[5:3];

  always_comb begin
    op_a = '0;
    case (sel_a)
      FWD_RF:   op_a = rf_a;
      FWD_ALU:  op_a = alu_q;
      FWD_WB:   op_a = wb_q;
      FWD_ZERO: op_a = '0;
      default:  op_a = '0;
    endcase
  end

  // The forwarded B survives as store data even when the immediate replaces it.
  always_comb begin
    fwd_b = '0;
    case (sel_b)
      FWD_RF:   fwd_b = rf_b;
      FWD_ALU:  fwd_b = alu_q;
      FWD_WB:   fwd_b = wb_q;
      FWD_ZERO: fwd_b = '0;
      default:  fwd_b = '0;
    endcase
  end

  assign op_b = imm_sel ? imm_ext : fwd_b;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLL: alu_res = op_a << op_b[4:0];
      ALU_SRL: alu_res = op_a >> op_b[4:0];
      default: alu_res = '0;
    endcase
  end

  // Word address wraps: upper ALU bits are simply dropped.
  assign dm_addr  = alu_q[DM_AW-1:0];
  assign dm_rdata = dmem[dm_addr];
  assign wb_next  = mem_mux_sel_dm ? dm_rdata : alu_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_q     <= '0;
      store_q   <= '0;
      mem_en_q  <= 1'b0;
      mem_rw_q  <= 1'b0;
      wb_q      <= '0;
      wb_addr_q <= '0;
      wb_en_q   <= 1'b0;
    end else begin
      alu_q     <= alu_res;
      store_q   <= fwd_b;
      mem_en_q  <= mem_en_ex;
      mem_rw_q  <= mem_rw_ex;
      wb_q      <= wb_next;
      wb_addr_q <= RW_dm;
      wb_en_q   <= (RW_dm != 5'd0);
    end
  end

  // A reset landing on a store's DM cycle must cancel that write.
  always_ff @(posedge clk) begin
    if (reset && mem_en_q && mem_rw_q) begin
      dmem[dm_addr] <= store_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en_q) begin
      rf[wb_addr_q] <= wb_q;
    end
  end

  assign alu_out = alu_q;
  assign wb_data = wb_q;
  assign wb_addr = wb_addr_q;
  assign wb_en   = wb_en_q;

endmodule

// File: tb/tb_forwarding_exec_pipe.sv
// Table-driven bench for forwarding_exec_pipe: each row is one instruction,
// with its EX fields driven in one cycle and its DM fields in the next.
module tb_forwarding_exec_pipe;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_AND = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_XOR = 6'd4;
  localparam logic [5:0] OP_SLT = 6'd5;
  localparam logic [5:0] OP_SLL = 6'd6;
  localparam logic [5:0] OP_SRL = 6'd7;
  localparam int NVEC = 33;

  typedef struct {
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] imm;
    logic [5:0]  op;
    logic        imm_sel;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic        mem_en;
    logic        mem_rw;
    logic [4:0]  rw;
    logic        mem_mux;
    logic [31:0] exp_alu;
    logic [31:0] exp_wb;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [15:0] imm;
  logic [5:0]  op_dec;
  logic        imm_sel;
  logic [1:0]  mux_sel_A;
  logic [1:0]  mux_sel_B;
  logic        mem_en_ex;
  logic        mem_rw_ex;
  logic [4:0]  RW_dm;
  logic        mem_mux_sel_dm;
  logic [31:0] alu_out;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_en;

  int checks;
  int errors;

  vec_t        vecs [NVEC];
  vec_t        prev;
  logic        prev_valid;
  logic [31:0] alu_exp_q [$];
  logic [31:0] wb_exp_q [$];
  logic [4:0]  wb_addr_exp_q [$];

  forwarding_exec_pipe #(.DM_AW(6), .XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .RA             (RA),
    .RB             (RB),
    .imm            (imm),
    .op_dec         (op_dec),
    .imm_sel        (imm_sel),
    .mux_sel_A      (mux_sel_A),
    .mux_sel_B      (mux_sel_B),
    .mem_en_ex      (mem_en_ex),
    .mem_rw_ex      (mem_rw_ex),
    .RW_dm          (RW_dm),
    .mem_mux_sel_dm (mem_mux_sel_dm),
    .alu_out        (alu_out),
    .wb_data        (wb_data),
    .wb_addr        (wb_addr),
    .wb_en          (wb_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pops whatever the scoreboard says is due after this edge.
  task automatic checkOutput(input int idx);
    logic [31:0] e;
    logic [4:0]  ea;
    if (alu_exp_q.size() > 0) begin
      e = alu_exp_q.pop_front();
      compareValue($sformatf("alu_out step %0d", idx), alu_out, e);
    end
    if (wb_exp_q.size() > 0) begin
      e  = wb_exp_q.pop_front();
      ea = wb_addr_exp_q.pop_front();
      compareValue($sformatf("wb_data step %0d", idx), wb_data, e);
      compareValue($sformatf("wb_addr step %0d", idx), {27'd0, wb_addr}, {27'd0, ea});
      compareValue($sformatf("wb_en step %0d", idx), {31'd0, wb_en}, {31'd0, (ea != 5'd0)});
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    RA        = v.ra;
    RB        = v.rb;
    imm       = v.imm;
    op_dec    = v.op;
    imm_sel   = v.imm_sel;
    mux_sel_A = v.sel_a;
    mux_sel_B = v.sel_b;
    mem_en_ex = v.mem_en;
    mem_rw_ex = v.mem_rw;
    RW_dm          = prev_valid ? prev.rw : 5'd0;
    mem_mux_sel_dm = prev_valid ? prev.mem_mux : 1'b0;
    alu_exp_q.push_back(v.exp_alu);
    if (prev_valid) begin
      wb_exp_q.push_back(prev.exp_wb);
      wb_addr_exp_q.push_back(prev.rw);
    end
    prev       = v;
    prev_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  task automatic checkPipeCleared(input string tag);
    compareValue({tag, " alu_out"}, alu_out, 32'd0);
    compareValue({tag, " wb_data"}, wb_data, 32'd0);
    compareValue({tag, " wb_addr"}, {27'd0, wb_addr}, 32'd0);
    compareValue({tag, " wb_en"}, {31'd0, wb_en}, 32'd0);
  endtask

  function automatic vec_t bubble();
    vec_t b;
    b = '{5'd0, 5'd0, 16'd0, OP_ADD, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0};
    return b;
  endfunction

  initial begin
    checks     = 0;
    errors     = 0;
    prev_valid = 1'b0;
    prev       = bubble();

    //           ra     rb     imm        op       is    sa    sb    men   mrw   rw     mm    alu            wb
    vecs[0]  = '{5'd5, 5'd7, 16'h0000, OP_ADD, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{5'd0, 5'd0, 16'h0005, OP_ADD, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 5'd1,  1'b0, 32'h0000_0005, 32'h0000_0005};
    vecs[2]  = '{5'd0, 5'd0, 16'h0003, OP_ADD, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 5'd4,  1'b0, 32'h0000_0008, 32'h0000_0008};
    vecs[3]  = '{5'd1, 5'd1, 16'h0000, OP_ADD, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 5'd5,  1'b0, 32'h0000_0005, 32'h0000_0005};
    vecs[4]  = '{5'd1, 5'd1, 16'h0000, OP_ADD, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_000A, 32'h0000_000A};
    vecs[5]  = '{5'd0, 5'd0, 16'h0000, OP_ADD, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_000A, 32'h0000_000A};
    vecs[6]  = '{5'd0, 5'd0, 16'h1234, OP_ADD, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 5'd2,  1'b0, 32'h0000_1234, 32'h0000_1234};
    vecs[7]  = '{5'd0, 5'd0, 16'h0004, OP_ADD, 1'b1, 2'd0, 2'd1, 1'b1, 1'b1, 5'd0,  1'b0, 32'h0000_0004, 32'h0000_0004};
    vecs[8]  = '{5'd0, 5'd0, 16'h0004, OP_ADD, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 5'd3,  1'b1, 32'h0000_0004, 32'h0000_1234};
    vecs[9]  = bubble();
    vecs[10] = '{5'd2, 5'd0, 16'h0000, OP_ADD, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_1234, 32'h0000_1234};
    vecs[11] = '{5'd3, 5'd2, 16'h0000, OP_ADD, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_2468, 32'h0000_2468};
    vecs[12] = '{5'd0, 5'd0, 16'h0001, OP_SUB, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 5'd6,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[13] = '{5'd0, 5'd0, 16'h0001, OP_SLT, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_0001, 32'h0000_0001};
    vecs[14] = '{5'd0, 5'd0, 16'h001F, OP_SLL, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 5'd7,  1'b0, 32'h8000_0000, 32'h8000_0000};
    vecs[15] = '{5'd0, 5'd0, 16'h001F, OP_SRL, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_0001, 32'h0000_0001};
    vecs[16] = '{5'd0, 5'd0, 16'hFFFF, OP_ADD, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[17] = '{5'd6, 5'd0, 16'h0F0F, OP_AND, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_0F0F, 32'h0000_0F0F};
    vecs[18] = '{5'd0, 5'd0, 16'h7000, OP_OR,  1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_7F0F, 32'h0000_7F0F};
    vecs[19] = '{5'd7, 5'd6, 16'h0000, OP_XOR, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vecs[20] = '{5'd0, 5'd0, 16'h0001, OP_SLT, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[21] = '{5'd0, 5'd0, 16'h0007, OP_ADD, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_0007, 32'h0000_0007};
    vecs[22] = bubble();
    vecs[23] = bubble();
    vecs[24] = '{5'd0, 5'd0, 16'h0000, OP_ADD, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[25] = '{5'd0, 5'd0, 16'h5A5A, OP_ADD, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 5'd8,  1'b0, 32'h0000_5A5A, 32'h0000_5A5A};
    vecs[26] = '{5'd0, 5'd0, 16'h0042, OP_ADD, 1'b1, 2'd0, 2'd1, 1'b1, 1'b1, 5'd0,  1'b0, 32'h0000_0042, 32'h0000_0042};
    vecs[27] = '{5'd0, 5'd0, 16'h0002, OP_ADD, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 5'd9,  1'b1, 32'h0000_0002, 32'h0000_5A5A};
    vecs[28] = '{5'd0, 5'd0, 16'h0042, OP_ADD, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 5'd10, 1'b1, 32'h0000_0042, 32'h0000_5A5A};
    vecs[29] = '{5'd0, 5'd0, 16'h0009, 6'h28,  1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_5A63, 32'h0000_5A63};
    vecs[30] = '{5'd6, 5'd6, 16'h0000, OP_ADD, 1'b0, 2'd3, 2'd3, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[31] = bubble();
    vecs[32] = bubble();

    // Hold reset for two edges with every input idle.
    reset          = 1'b0;
    RA             = '0;
    RB             = '0;
    imm            = '0;
    op_dec         = '0;
    imm_sel        = 1'b0;
    mux_sel_A      = '0;
    mux_sel_B      = '0;
    mem_en_ex      = 1'b0;
    mem_rw_ex      = 1'b0;
    RW_dm          = '0;
    mem_mux_sel_dm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkPipeCleared("reset");
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Store 0x5A5A to mem[5], then a second store whose DM cycle is hit by reset.
    applyStimulus('{5'd0, 5'd8, 16'h0005, OP_ADD, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 5'd0, 1'b0,
                    32'h0000_0005, 32'h0000_0005}, 100);
    applyStimulus(bubble(), 101);
    applyStimulus('{5'd0, 5'd2, 16'h0005, OP_ADD, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 5'd0, 1'b0,
                    32'h0000_0005, 32'h0000_0005}, 102);
    RA             = '0;
    RB             = '0;
    imm            = '0;
    op_dec         = OP_ADD;
    imm_sel        = 1'b0;
    mux_sel_A      = '0;
    mux_sel_B      = '0;
    mem_en_ex      = 1'b0;
    mem_rw_ex      = 1'b0;
    RW_dm          = prev.rw;
    mem_mux_sel_dm = prev.mem_mux;
    reset          = 1'b0;
    @(posedge clk);
    #1;
    checkPipeCleared("midreset");
    reset      = 1'b1;
    prev_valid = 1'b0;

    // mem[5] keeps the first store; the register file was wiped.
    applyStimulus('{5'd0, 5'd0, 16'h0005, OP_ADD, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 5'd12, 1'b1,
                    32'h0000_0005, 32'h0000_5A5A}, 103);
    applyStimulus('{5'd8, 5'd2, 16'h0000, OP_ADD, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0,
                    32'h0000_0000, 32'h0000_0000}, 104);
    applyStimulus(bubble(), 105);
    applyStimulus(bubble(), 106);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
